// File: rtl/resn_conditioner.sv
// Conditions the raw board reset pin into a clean, debounced, minimum-width
// active-low reset for the core: synchroniser -> debounce FSM -> stretch.
`timescale 1ns/1ps

module resn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int PULSE_CYCLES    = 160000
) (
  input  logic       clock_160,
  input  logic       resn,
  input  logic       raw_resn,
  output logic       prop_resn,
  output logic       rst_event,
  output logic [1:0] state
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = '1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  state_e                 state_q, state_d;
  logic                   prop_resn_q, prop_resn_d;
  logic                   rst_event_q, rst_event_d;
  logic                   s;

  // The FSM only ever looks at the last synchroniser stage.
  assign s = sync_q[SYNC_STAGES-1];

  // State register: the synchroniser, counter, FSM state and registered outputs.
  always_ff @(posedge clock_160) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!resn) begin
      sync_q      <= '1;
      cnt_q       <= '0;
      state_q     <= ST_ASSERT;
      prop_resn_q <= 1'b0;
      rst_event_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      prop_resn_q <= prop_resn_d;
      rst_event_q <= rst_event_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_resn};
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
  end

  // Next-state logic; the counter is cleared on every state change except
  // RUN->QUALIFY, where the first low sample already counts toward debounce.
  always_comb begin
    // NOTE: defaults first so every path assigns every output: no latches.
    state_d = state_q;
    cnt_d   = cnt_inc;
    unique case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (!s) begin
          state_d = ST_QUALIFY;
          cnt_d   = CW'(1);
        end
      end
      ST_QUALIFY: begin
        if (s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (!s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the transition that causes them.
  always_comb begin
    prop_resn_d = (state_d == ST_RUN) || (state_d == ST_QUALIFY);
    rst_event_d = (state_q == ST_QUALIFY) && (state_d == ST_ASSERT);
  end

  assign prop_resn = prop_resn_q;
  assign rst_event = rst_event_q;
  assign state     = state_q;

endmodule
